bisection_ctrl: RTL and testbench

Second-generation bisection search engine that drives the reference-current code i_ref so that the measured Q converges to q_desired.
- Adds programmable search bounds, an explicit measurement request/valid handshake and a settle delay.
- Adds an iteration cap with converged/fail status.
- Sits between the control register block (targets, bounds) and the Q measurement front-end. It runs one search per start pulse.

---
 rtl/bisection_ctrl_if.sv | 40 ++++
 rtl/bisection_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bisection_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bisection_ctrl_if.sv
// Bus between the control register block / Q measurement front-end and the
// bisection search engine. The engine connects through the slave modport; the
// register block and the measurement front-end (or a bench) use master.
//
// Handshake: meas_req is a level request raised by the engine once i_ref has
// settled. The measurement front-end answers with a one-cycle meas_valid
// strobe carrying q_measured. The engine takes the first meas_valid seen while
// meas_req is high, then drops meas_req on the next cycle. A meas_valid
// strobe that arrives while no request is outstanding is ignored. meas_valid
// is never back-pressured.
interface bisection_ctrl_if #(
   parameter int BUS_WIDTH = 10,
   parameter int MAX_ITER  = 16
);
   localparam int IW = $clog2(MAX_ITER + 1);

   logic                 enable;
   logic                 start;
   logic [BUS_WIDTH-1:0] q_desired;
   logic [BUS_WIDTH-1:0] q_measured;
   logic                 meas_valid;
   logic [BUS_WIDTH-1:0] lo_bound;
   logic [BUS_WIDTH-1:0] hi_bound;
   logic [BUS_WIDTH-1:0] i_ref;
   logic                 meas_req;
   logic                 busy;
   logic                 converged;
   logic                 fail;
   logic [IW-1:0]        iter_count;

   modport master (
      output enable, start, q_desired, q_measured, meas_valid, lo_bound, hi_bound,
      input  i_ref, meas_req, busy, converged, fail, iter_count
   );

   modport slave (
      input  enable, start, q_desired, q_measured, meas_valid, lo_bound, hi_bound,
      output i_ref, meas_req, busy, converged, fail, iter_count
   );
endinterface

// File: rtl/bisection_ctrl.sv
// Bisection search engine: steps the reference-current code i_ref inside a
// programmable [lo_bound, hi_bound] window until the measured Q lands within
// TOL of q_desired, the iteration cap is reached or the interval collapses.
// Optional macro BISECT_TRACK_EN: once converged, keep re-measuring while
// sitting in DONE and restart the search if Q drifts out of tolerance.
module bisection_ctrl #(
   parameter int BUS_WIDTH  = 10,
   parameter int TOL        = 1,
   parameter int MAX_ITER   = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic            clk,
   input  logic            rst,
   bisection_ctrl_if.slave bus,
   output logic [2:0]      state_dbg
);
   localparam int IW  = $clog2(MAX_ITER + 1);
   localparam int SW  = $clog2(SETTLE_CYC + 1);
   localparam int BW1 = BUS_WIDTH + 1;
   localparam logic [BW1-1:0] TOL_V    = BW1'(TOL);
   localparam logic [IW-1:0]  MAX_V    = IW'(MAX_ITER);
   localparam logic [SW-1:0]  SETTLE_V = SW'(SETTLE_CYC);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, MEASURE, UPDATE, DONE} state_t;

   state_t               state;
   logic [BUS_WIDTH-1:0] a;
   logic [BUS_WIDTH-1:0] b;
   logic [BUS_WIDTH-1:0] q_smp;
   logic [SW-1:0]        settle_cnt;

   logic [BUS_WIDTH-1:0] q_cmp;
   logic signed [BW1-1:0] diff;
   logic [BW1-1:0]       err;
   logic [BUS_WIDTH-1:0] mid;
   logic                 go_up;
   logic [BUS_WIDTH-1:0] a_nxt;
   logic [BUS_WIDTH-1:0] b_nxt;
   logic [BUS_WIDTH-1:0] span;
   logic [IW-1:0]        iter_nxt;

   assign state_dbg = state;

   // Error magnitude, probe midpoint and candidate next interval
   always_comb begin
      q_cmp = q_smp;
`ifdef BISECT_TRACK_EN
      if (state == DONE) q_cmp = bus.q_measured;
`endif
      diff     = $signed({1'b0, q_cmp}) - $signed({1'b0, bus.q_desired});
      err      = diff[BW1-1] ? $unsigned(-diff) : $unsigned(diff);
      mid      = a + ((b - a) >> 1);
      go_up    = bus.q_desired > q_smp;
      a_nxt    = go_up ? bus.i_ref : a;
      b_nxt    = go_up ? b : bus.i_ref;
      span     = b_nxt - a_nxt;
      iter_nxt = bus.iter_count + IW'(1);
   end

   // Search sequencer with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         a              <= '0;
         b              <= '0;
         q_smp          <= '0;
         settle_cnt     <= '0;
         bus.i_ref      <= '0;
         bus.meas_req   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.converged  <= 1'b0;
         bus.fail       <= 1'b0;
         bus.iter_count <= '0;
      end else if (!bus.enable) begin
         state        <= IDLE;
         bus.meas_req <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  bus.meas_req   <= 1'b0;
                  bus.converged  <= 1'b0;
                  bus.iter_count <= '0;
                  if (bus.lo_bound > bus.hi_bound) begin
                     // Empty window: report failure without measuring
                     bus.fail  <= 1'b1;
                     bus.i_ref <= bus.lo_bound;
                     state     <= DONE;
                  end else begin
                     a        <= bus.lo_bound;
                     b        <= bus.hi_bound;
                     bus.fail <= 1'b0;
                     bus.busy <= 1'b1;
                     state    <= LOAD;
                  end
               end
`ifdef BISECT_TRACK_EN
               else if (state == DONE && bus.converged) begin
                  if (!bus.meas_req) begin
                     if (settle_cnt <= SW'(1)) bus.meas_req <= 1'b1;
                     else settle_cnt <= settle_cnt - SW'(1);
                  end else if (bus.meas_valid) begin
                     bus.meas_req <= 1'b0;
                     settle_cnt   <= SETTLE_V;
                     if (err >= TOL_V) begin
                        bus.converged  <= 1'b0;
                        bus.iter_count <= '0;
                        a              <= bus.lo_bound;
                        b              <= bus.hi_bound;
                        bus.busy       <= 1'b1;
                        state          <= LOAD;
                     end
                  end
               end
`endif
            end
            LOAD: begin
               bus.i_ref  <= mid;
               settle_cnt <= SETTLE_V;
               state      <= SETTLE;
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - SW'(1);
               if (settle_cnt == SW'(1)) begin
                  bus.meas_req <= 1'b1;
                  state        <= MEASURE;
               end
            end
            MEASURE: begin
               if (bus.meas_valid) begin
                  q_smp        <= bus.q_measured;
                  bus.meas_req <= 1'b0;
                  state        <= UPDATE;
               end
            end
            UPDATE: begin
               if (err < TOL_V) begin
                  bus.converged <= 1'b1;
                  bus.busy      <= 1'b0;
                  settle_cnt    <= SETTLE_V;
                  state         <= DONE;
               end else begin
                  bus.iter_count <= iter_nxt;
                  if (iter_nxt == MAX_V) begin
                     bus.fail <= 1'b1;
                     bus.busy <= 1'b0;
                     state    <= DONE;
                  end else begin
                     a <= a_nxt;
                     b <= b_nxt;
                     if (span <= BUS_WIDTH'(1)) begin
                        // Adjacent codes: no midpoint left to probe
                        bus.fail <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                     end else begin
                        state <= LOAD;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bisection_ctrl.sv
// Bench for bisection_ctrl: directed spec scenarios plus randomized searches
// scored against an arithmetic reference model of the bisection rules.
module tb_bisection_ctrl;
   localparam int BW       = 10;
   localparam int TOL      = 1;
   localparam int MAX_ITER = 16;
   localparam int CAP_ITER = 4;
   localparam int SETTLE   = 4;

   logic       clk;
   logic       rst;
   logic [2:0] state_dbg;
   logic [2:0] state_dbg4;

   bisection_ctrl_if #(.BUS_WIDTH(BW), .MAX_ITER(MAX_ITER)) ifc ();
   bisection_ctrl_if #(.BUS_WIDTH(BW), .MAX_ITER(CAP_ITER)) ifc4 ();

   bisection_ctrl #(.BUS_WIDTH(BW), .TOL(TOL), .MAX_ITER(MAX_ITER), .SETTLE_CYC(SETTLE)) dut (
      .clk(clk), .rst(rst), .bus(ifc), .state_dbg(state_dbg)
   );

   bisection_ctrl #(.BUS_WIDTH(BW), .TOL(TOL), .MAX_ITER(CAP_ITER), .SETTLE_CYC(SETTLE)) dut_cap (
      .clk(clk), .rst(rst), .bus(ifc4), .state_dbg(state_dbg4)
   );

   int checks   = 0;
   int failures = 0;

   logic [BW-1:0] exp_q[$];
   int plant_mode = 0;
   bit plant_on   = 1'b1;
   int max_delay  = 0;
   bit tmon_on    = 1'b0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] plant_fn(input int mode, input int c);
      case (mode)
         0:       return BW'(c);
         1:       return BW'(2 * c);
         default: return BW'(1023 - c);
      endcase
   endfunction

   // Reference: plain interval halving over integers
   task automatic model(input int lo, input int hi, input int qd, input int mode, input int maxit,
                        output int e_iref, output int e_conv, output int e_fail, output int e_iter);
      int lo_v, hi_v, c, q, d;
      exp_q.delete();
      e_conv = 0; e_fail = 0; e_iter = 0; e_iref = lo;
      if (lo > hi) begin
         e_fail = 1;
         return;
      end
      lo_v = lo; hi_v = hi;
      forever begin
         c = (lo_v + hi_v) / 2;
         exp_q.push_back(BW'(c));
         e_iref = c;
         q = int'(plant_fn(mode, c));
         d = (q > qd) ? q - qd : qd - q;
         if (d < TOL) begin e_conv = 1; break; end
         e_iter++;
         if (e_iter == maxit) begin e_fail = 1; break; end
         if (qd > q) lo_v = c; else hi_v = c;
         if (hi_v - lo_v <= 1) begin e_fail = 1; break; end
      end
   endtask

   // ---------------- measurement plants ----------------
   initial begin : plant_main
      int wait_cnt;
      wait_cnt = 0;
      ifc.meas_valid = 1'b0;
      ifc.q_measured = '0;
      forever begin
         @(negedge clk);
         ifc.meas_valid = 1'b0;
         if (plant_on && ifc.meas_req && ifc.busy) begin
            if (wait_cnt == 0) begin
               ifc.q_measured = plant_fn(plant_mode, int'(ifc.i_ref));
               ifc.meas_valid = 1'b1;
               wait_cnt = $urandom_range(max_delay, 0);
               if (exp_q.size() == 0) check("extra_meas", 1, 0);
               else check("iref_seq", 32'(ifc.i_ref), 32'(exp_q.pop_front()));
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   initial begin : plant_cap
      ifc4.meas_valid = 1'b0;
      ifc4.q_measured = '0;
      forever begin
         @(negedge clk);
         ifc4.meas_valid = 1'b0;
         if (ifc4.meas_req) begin
            ifc4.q_measured = ifc4.i_ref;
            ifc4.meas_valid = 1'b1;
         end
      end
   end

   // i_ref change to meas_req rise must take SETTLE cycles
   initial begin : timing_mon
      int since;
      logic [BW-1:0] prev_iref;
      logic prev_req;
      since = 0; prev_iref = '0; prev_req = 1'b0;
      forever begin
         @(negedge clk);
         since++;
         if (ifc.i_ref !== prev_iref) since = 0;
         if (tmon_on && ifc.meas_req && !prev_req) check("iref_to_req", since, SETTLE);
         prev_iref = ifc.i_ref;
         prev_req  = ifc.meas_req;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_search(input int lo, input int hi, input int qd);
      @(negedge clk);
      ifc.lo_bound  = BW'(lo);
      ifc.hi_bound  = BW'(hi);
      ifc.q_desired = BW'(qd);
      ifc.start     = 1'b1;
      @(negedge clk);
      ifc.start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (ifc.busy === 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_finished"}, 32'(ifc.busy), 0);
   endtask

   task automatic run_case(input string tag, input int lo, input int hi, input int qd, input int mode);
      int ei, ec, ef, eit;
      model(lo, hi, qd, mode, MAX_ITER, ei, ec, ef, eit);
      plant_mode = mode;
      start_search(lo, hi, qd);
      wait_done(tag, 2000);
      check({tag, "_iref"}, 32'(ifc.i_ref), ei);
      check({tag, "_conv"}, 32'(ifc.converged), ec);
      check({tag, "_fail"}, 32'(ifc.fail), ef);
      check({tag, "_iter"}, 32'(ifc.iter_count), eit);
      check({tag, "_meas_left"}, exp_q.size(), 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin : main
      int cyc;
      bit saw;
      int lo, hi, tmp;
      ifc.enable = 1'b1; ifc.start = 1'b0;
      ifc.q_desired = '0; ifc.lo_bound = '0; ifc.hi_bound = '0;
      ifc4.enable = 1'b1; ifc4.start = 1'b0;
      ifc4.q_desired = '0; ifc4.lo_bound = '0; ifc4.hi_bound = '0;
      rst = 1'b1;

      @(negedge clk);
      check("rst_iref", 32'(ifc.i_ref), 0);
      check("rst_meas_req", 32'(ifc.meas_req), 0);
      check("rst_busy", 32'(ifc.busy), 0);
      check("rst_conv", 32'(ifc.converged), 0);
      check("rst_fail", 32'(ifc.fail), 0);
      check("rst_iter", 32'(ifc.iter_count), 0);
      apply_reset(2);

      // Nominal: identity plant, answer one cycle after the request
      exp_q = '{10'd511, 10'd255, 10'd383, 10'd319, 10'd287, 10'd303, 10'd295, 10'd299, 10'd301, 10'd300};
      plant_mode = 0; max_delay = 0; tmon_on = 1'b1;
      start_search(0, 1023, 300);
      cyc = 1;
      while (!ifc.meas_req && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("start_to_req", cyc, SETTLE + 2);
      wait_done("nominal", 2000);
      tmon_on = 1'b0;
      check("nominal_iref", 32'(ifc.i_ref), 300);
      check("nominal_conv", 32'(ifc.converged), 1);
      check("nominal_fail", 32'(ifc.fail), 0);
      check("nominal_iter", 32'(ifc.iter_count), 9);
      check("nominal_meas_left", exp_q.size(), 0);

      // Invalid bounds
      start_search(600, 500, 300);
      check("inv_busy", 32'(ifc.busy), 0);
      check("inv_fail", 32'(ifc.fail), 1);
      check("inv_iref", 32'(ifc.i_ref), 600);
      check("inv_conv", 32'(ifc.converged), 0);
      saw = 1'b0;
      repeat (12) begin
         @(negedge clk);
         saw |= ifc.meas_req;
      end
      check("inv_no_req", 32'(saw), 0);

      // Iteration cap on the MAX_ITER=4 instance
      @(negedge clk);
      ifc4.lo_bound = 10'd0; ifc4.hi_bound = 10'd1023; ifc4.q_desired = 10'd300; ifc4.start = 1'b1;
      @(negedge clk);
      ifc4.start = 1'b0;
      cyc = 0;
      while (ifc4.busy === 1'b1 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("cap_finished", 32'(ifc4.busy), 0);
      check("cap_fail", 32'(ifc4.fail), 1);
      check("cap_conv", 32'(ifc4.converged), 0);
      check("cap_iter", 32'(ifc4.iter_count), CAP_ITER);
      check("cap_iref", 32'(ifc4.i_ref), 319);

      // Collapse: q = 2*i_ref cannot hit an odd target
      max_delay = 2;
      run_case("collapse", 0, 1023, 301, 1);

      // Abort by enable during MEASURE
      plant_on = 1'b0;
      start_search(0, 1023, 300);
      cyc = 0;
      while (!ifc.meas_req && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_req_seen", 32'(ifc.meas_req), 1);
      ifc.enable = 1'b0;
      @(negedge clk);
      check("abort_meas_req", 32'(ifc.meas_req), 0);
      check("abort_busy", 32'(ifc.busy), 0);
      check("abort_iref_hold", 32'(ifc.i_ref), 511);
      ifc.enable = 1'b1;
      #2;
      ifc.q_measured = 10'd300;
      ifc.meas_valid = 1'b1;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         saw |= ifc.meas_req | ifc.busy | ifc.converged;
      end
      check("abort_valid_ignored", 32'(saw), 0);
      check("abort_iter", 32'(ifc.iter_count), 0);
      plant_on = 1'b1;

      // Asynchronous reset while settling
      exp_q.delete();
      start_search(0, 1023, 300);
      @(negedge clk);
      check("pre_rst_busy", 32'(ifc.busy), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_iref", 32'(ifc.i_ref), 0);
      check("arst_meas_req", 32'(ifc.meas_req), 0);
      check("arst_busy", 32'(ifc.busy), 0);
      check("arst_conv", 32'(ifc.converged), 0);
      check("arst_fail", 32'(ifc.fail), 0);
      check("arst_iter", 32'(ifc.iter_count), 0);
      @(negedge clk);
      rst = 1'b0;
      max_delay = 0;
      run_case("after_rst", 0, 1023, 300, 0);

      // Randomized searches
      for (int i = 0; i < 25; i++) begin
         lo = $urandom_range(1023, 0);
         hi = $urandom_range(1023, 0);
         if ($urandom_range(4, 0) != 0 && lo > hi) begin
            tmp = lo; lo = hi; hi = tmp;
         end
         max_delay = $urandom_range(3, 0);
         run_case("rand", lo, hi, $urandom_range(1023, 0), $urandom_range(2, 0));
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
